// File: rtl/fir_tap_mac_seq_if.sv
// Handshake, coefficient-write and multiplier-side signals of the FIR tap sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface fir_tap_mac_seq_if #(
  parameter int N_TAPS = 11,
  parameter int DATA_W = 32,
  parameter int COEF_W = 6
);
  localparam int AW = $clog2(N_TAPS);

  logic [DATA_W-1:0] x_data;
  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] y_data;
  logic              y_valid;
  logic              y_ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              busy;
  logic [COEF_W-1:0] mul_din0;
  logic [DATA_W-1:0] mul_din1;
  logic              mul_ce;
  logic [DATA_W-1:0] mul_dout;

  modport slave (
    input  x_data, x_valid, y_ready, coef_we, coef_addr, coef_wdata, mul_dout,
    output x_ready, y_data, y_valid, busy, mul_din0, mul_din1, mul_ce
  );

  modport master (
    output x_data, x_valid, y_ready, coef_we, coef_addr, coef_wdata, mul_dout,
    input  x_ready, y_data, y_valid, busy, mul_din0, mul_din1, mul_ce
  );
endinterface

// File: rtl/fir_tap_mac_seq.sv
// FIR tap sequencer: circular delay line, coefficient file, per-tap multiplier issue
// and modulo-2^DATA_W accumulation of the returning products into one output per sample.
module fir_tap_mac_seq #(
  parameter int N_TAPS  = 11,
  parameter int DATA_W  = 32,
  parameter int COEF_W  = 6,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  fir_tap_mac_seq_if.slave bus
);
  localparam int AW = $clog2(N_TAPS);
  localparam int DW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t            state;
  logic              rst_done;
  logic [AW-1:0]     head;
  logic [AW-1:0]     tap_idx;
  logic [AW-1:0]     rd_idx;
  logic [AW:0]       rd_sum;
  logic [DW-1:0]     drain_cnt;
  logic [DATA_W-1:0] dline [N_TAPS];
  logic [COEF_W-1:0] coef  [N_TAPS];
  logic [MUL_LAT-1:0] pv;
  logic [MUL_LAT-1:0] pl;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] y_data_q;
  logic              y_valid_q;
  logic              accept;
  logic              coef_ok;
  logic              issue;
  logic              issue_last;

  // head already points past the newest sample, so tap i lives at head-1-i (mod N_TAPS)
  always_comb begin
    accept     = (state == IDLE) && rst_done && bus.x_valid;
    coef_ok    = bus.coef_we && (state == IDLE) &&
                 ({1'b0, bus.coef_addr} < (AW+1)'(N_TAPS));
    issue      = (state == MAC);
    issue_last = issue && (tap_idx == AW'(N_TAPS - 1));
    rd_sum     = {1'b0, head} + (AW+1)'(N_TAPS - 1) - {1'b0, tap_idx};
    rd_idx     = (rd_sum >= (AW+1)'(N_TAPS)) ? AW'(rd_sum - (AW+1)'(N_TAPS)) : AW'(rd_sum);
  end

  assign bus.x_ready  = (state == IDLE) && rst_done;
  assign bus.busy     = (state != IDLE);
  assign bus.mul_ce   = (state == MAC) || (state == DRAIN);
  assign bus.mul_din0 = issue ? coef[tap_idx] : '0;
  assign bus.mul_din1 = issue ? dline[rd_idx] : '0;
  assign bus.y_data   = y_data_q;
  assign bus.y_valid  = y_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rst_done  <= 1'b0;
      head      <= '0;
      tap_idx   <= '0;
      drain_cnt <= '0;
      dline     <= '{default: '0};
      coef      <= '{default: '0};
      pv        <= '0;
      pl        <= '0;
      acc       <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (coef_ok) coef[bus.coef_addr] <= bus.coef_wdata;

      // issue flags travel alongside the multiplier pipeline to mark when each product lands
      pv <= MUL_LAT'({pv, issue});
      pl <= MUL_LAT'({pl, issue_last});
      if (pv[MUL_LAT-1]) acc <= acc + bus.mul_dout;
      if (pl[MUL_LAT-1]) begin
        y_data_q  <= acc + bus.mul_dout;
        y_valid_q <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            dline[head] <= bus.x_data;
            head        <= (head == AW'(N_TAPS - 1)) ? '0 : head + 1'b1;
            acc         <= '0;
            tap_idx     <= '0;
            state       <= MAC;
          end
        end
        MAC: begin
          if (issue_last) begin
            tap_idx   <= '0;
            drain_cnt <= '0;
            state     <= (MUL_LAT > 1) ? DRAIN : OUT;
          end else begin
            tap_idx <= tap_idx + 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DW'(MUL_LAT - 2)) state <= OUT;
        end
        OUT: begin
          if (y_valid_q && bus.y_ready) begin
            y_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fir_tap_mac_seq.md
# fir_tap_mac_seq

Sequencing stage of the FIR datapath, wrapped around the registered 6-bit × 32-bit signed multiplier. It accepts one input sample per handshake and stores it in an N-tap delay line. It then streams (coefficient, delayed-sample) pairs into the multiplier, one per cycle, and accumulates the returning products into one 32-bit output per sample. The coefficients are held in a small writable register file.

## Interface
Parameters:
- N_TAPS, 11, number of taps and delay-line depth (≥2)
- DATA_W, 32, sample, product and accumulator width
- COEF_W, 6, signed coefficient width
- MUL_LAT, 1, register stages in the attached multiplier (issue edge to product-visible edge)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- x_data  in  DATA_W  signed input sample
- x_valid  in  1  sample offered
- x_ready  out  1  sample accepted when x_valid & x_ready at an edge
- y_data  out  DATA_W  signed filter output
- y_valid  out  1  output held valid
- y_ready  in  1  consumer accepts the output
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(N_TAPS)  coefficient index
- coef_wdata  in  COEF_W  signed coefficient value
- busy  out  1  high whenever state ≠ IDLE
- mul_din0  out  COEF_W  coefficient to the multiplier
- mul_din1  out  DATA_W  sample to the multiplier
- mul_ce  out  1  multiplier clock enable
- mul_dout  in  DATA_W  product from the multiplier, MUL_LAT edges after issue

## Operation
- State machine:
  - IDLE → MAC on x handshake.
  - MAC runs N_TAPS cycles, tap_idx 0..N_TAPS-1. It then goes to DRAIN.
  - DRAIN lasts MUL_LAT-1 cycles and is skipped if MUL_LAT=1. It then goes to OUT.
  - OUT → IDLE on y handshake.
- Delay line: a circular buffer of N_TAPS × DATA_W with a head pointer.
  - On accept, x_data is written at head and head advances, wrapping N_TAPS-1 → 0.
  - Tap i reads the sample written i accepts earlier, so tap 0 is the newest.
- MAC issue at tap_idx i: mul_din0 = coef[i], mul_din1 = x[n-i], mul_ce = 1.
  - mul_ce stays 1 through MAC and DRAIN and is 0 otherwise.
  - mul_din0/mul_din1 are 0 outside MAC.
- Accumulator: cleared on accept.
  - On each edge where a product issued MUL_LAT edges earlier is due, acc ← acc + mul_dout.
  - Arithmetic is modulo 2^DATA_W: two's-complement wrap, no saturation.
- Output: on the edge that adds the last product, y_data ← acc + mul_dout and y_valid ← 1.
  - y_data and y_valid are held stable in OUT until y_ready.
- x_ready = (state == IDLE) & rst_done. rst_done is a flop cleared by reset and set on the first edge after release.
- Coefficient writes:
  - Honoured only in IDLE, and only when coef_addr < N_TAPS.
  - Otherwise they are dropped silently.
  - A write and an x accept on the same edge both take effect; the new coefficient is used for that sample.
- Reset (async, any state):
  - State IDLE, head 0, delay line 0, coefficients 0, acc 0.
  - y_data 0, y_valid 0, x_ready 0, busy 0, mul_ce 0, mul_din0/1 0.
  - Reset during MAC/DRAIN/OUT aborts the sample; no y_valid is produced for it.

## Timing
- Accept at edge E0:
  - MAC covers the cycles after E0 … E(N_TAPS).
  - y_valid is visible after edge E(N_TAPS+MUL_LAT), i.e. E12 with defaults.
- With y_ready held 1:
  - The y handshake is at E(N_TAPS+MUL_LAT+1).
  - x_ready is high in the following cycle.
  - Sample period is N_TAPS+MUL_LAT+2 cycles, 14 with defaults.
- x_valid while busy is not accepted; the upstream stage holds x_data.
- y_ready low stalls in OUT indefinitely with no loss; x_ready stays 0 during the stall.

## Test plan
- **Reset values:** assert reset for 3 cycles, release → all outputs 0 during reset; x_ready rises exactly one edge after release.
- **Impulse response:** load coef[i] = i-5 (−5…5); send x=1 then ten 0s with y_ready=1 → y sequence −5,−4,…,5; each y_valid comes 12 edges after its accept; accept-to-accept spacing is 14 cycles.
- **Wrap arithmetic:** all coef = 0 except coef[0] = −32; send x = 0x7FFFFFFF → y_data = 0x00000020.
- **Backpressure:** hold y_ready=0 for 20 cycles after y_valid → y_data stable and x_ready 0 throughout; release → handshake, then next sample accepted one cycle later.
- **Dropped coefficient write:** issue coef_we while busy=1 → write dropped; impulse response unchanged. Issue coef_we with coef_addr=15 in IDLE → write ignored.
- **Mid-operation reset:** pulse reset at tap_idx 5 → no y_valid for that sample; after release, impulse x=1 with coef[0]=3 → y=3, confirming the delay line was zeroed.
